wall_datapath: RTL and testbench
================================

Name: wall_datapath

Overview:
- Datapath partner of the wall control FSM.
- Consumes the FSM's 4-bit state code `current` and returns `touched` to it.
- Owns the wall's x position and moves it left one STEP per frame tick while in W_MOVE.
- Runs an autonomous pixel-sweep engine that redraws the wall, and erases its vacated columns, on the VGA adapter plot interface.

Parameters:
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
- X_START, 159, wall x position after reset and in W_READY.
- Y_TOP, 60, top row of the wall.
- WALL_W, 4, wall width in pixels.
- WALL_H, 20, wall height in pixels.
- STEP, 1, pixels moved per accepted step.
- TOUCH_X, 20, player column; wall_x <= TOUCH_X means touched.
- WALL_COLOUR, 3'b111, wall pixel colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- current  in  4  wall FSM state code.
- step_en  in  1  one-cycle frame tick; gates movement.
- wall_x  out  8  current wall left column.
- touched  out  1  wall has reached the player column.
- x_out  out  8  VGA pixel x.
- y_out  out  7  VGA pixel y.
- colour  out  3  VGA pixel colour.
- plot  out  1  VGA write strobe.
- busy  out  1  sweep in progress.

Behaviour:
- Reset values (resetn=0 at a clk edge):
  - wall_x=X_START, touched=0.
  - busy=0, pending=0, plot=0.
  - x_out=0, y_out=0, colour=0.
  - Reset mid-sweep aborts the sweep: plot=0 and busy=0 from the next cycle.
- State codes:
  - W_READY=4'b0101, W_MOVE=4'b0110, W_STOP=4'b0111, W_DRAW=4'b1000.
  - Any other code: hold wall_x and touched; no draw request.
- Per-state position update (registered):
  - W_READY: wall_x <= X_START; touched <= 0.
  - W_MOVE with step_en=1: wall_x <= wall_x - STEP, saturating at 0.
  - W_MOVE with step_en=0: hold.
  - W_STOP: hold wall_x and touched.
- touched:
  - Registered compare on the next value of wall_x: touched <= (wall_x_next <= TOUCH_X), in all states except W_READY.
  - touched therefore changes on the same edge as wall_x.
- Draw request: every cycle with current==W_DRAW.
  - busy=0: sweep starts on that edge; snap_x <= wall_x.
  - busy=1: set pending. Multiple requests during a sweep coalesce into one.
- Sweep engine (sub-FSM: S_IDLE / S_SWEEP):
  - Counters cx in 0..WALL_W+STEP-1 (inner) and cy in 0..WALL_H-1 (outer); one pixel per cycle.
  - Pixel coordinates: x = snap_x + cx, computed 9 bits wide; y = Y_TOP + cy.
  - colour = WALL_COLOUR if cx < WALL_W, else BG_COLOUR (erases the columns vacated by the leftward move).
  - plot = 1 only if x < SCREEN_W. Clipped pixels still consume their cycle.
  - Outputs are registered. The first pixel appears the cycle after the request edge.
  - Sweep length = (WALL_W+STEP)*WALL_H cycles = 100 with defaults.
  - busy is high exactly for the sweep cycles.
  - After the last pixel: if pending, clear it and restart on the next edge, re-snapping wall_x. Otherwise go to S_IDLE, plot=0.
- wall_x changing mid-sweep does not affect the sweep in progress (snap_x is held).

Decomposition:
- Shared package wall_pkg:
  - The four state-code localparams, shared with the wall control FSM.
  - Colour constants.
  - Screen dimensions.
- One natural sub-module: pixel_sweep (counters, clipping, plot/busy generation). It is reusable by the player datapath.

Test Plan:
- Reset, then hold current=W_READY -> wall_x=159, touched=0, plot=0, busy=0 throughout.
- current=W_DRAW for 1 cycle with wall_x=159 -> busy high for 100 cycles. Exactly 20 plots: x=159, y=60..79, colour=3'b111. Columns 160..163 clipped (plot=0).
- current=W_MOVE with step_en=1 at wall_x=159 -> wall_x=158 next edge. With step_en=0 -> stays 159. With wall_x=0, step_en=1 -> stays 0.
- wall_x=21, W_MOVE with step_en=1 -> wall_x=20 and touched=1 on the same edge. Then W_STOP -> both hold. Then W_READY -> wall_x=159, touched=0.
- Three W_DRAW pulses during an active sweep -> exactly one follow-on sweep, starting the cycle after the first sweep's last pixel, using the updated wall_x.
- resetn=0 at pixel 50 of a sweep -> plot=0 and busy=0 next cycle. No further pixels until a new W_DRAW.

Source files
------------

// File: rtl/wall_pkg.sv
// rtl/wall_pkg.sv - shared wall state codes, colours and screen geometry
package wall_pkg;

  localparam logic [3:0] W_READY = 4'b0101;
  localparam logic [3:0] W_MOVE  = 4'b0110;
  localparam logic [3:0] W_STOP  = 4'b0111;
  localparam logic [3:0] W_DRAW  = 4'b1000;

  localparam logic [2:0] WALL_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic {S_IDLE, S_SWEEP} sweep_state_t;

endpackage

// File: rtl/wall_datapath_if.sv
// rtl/wall_datapath_if.sv - control-FSM and VGA plot signals of the wall datapath
interface wall_datapath_if;

  logic [3:0] current;
  logic       step_en;
  logic [7:0] wall_x;
  logic       touched;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    input  current, step_en,
    output wall_x, touched, x_out, y_out, colour, plot, busy
  );

  modport slave (
    output current, step_en,
    input  wall_x, touched, x_out, y_out, colour, plot, busy
  );

endinterface

// File: rtl/wall_datapath_pixel_sweep.sv
// rtl/wall_datapath_pixel_sweep.sv - rectangle sweep engine with clipping and coalesced restart
module pixel_sweep
  import wall_pkg::*;
#(
  parameter int          W     = 4,
  parameter int          H     = 20,
  parameter int          EXTRA = 1,
  parameter int          Y0    = 60,
  parameter int          SW    = SCREEN_W,
  parameter logic [2:0]  FG    = WALL_COLOUR,
  parameter logic [2:0]  BG    = BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic [7:0] x_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam logic [7:0] CX_LAST = 8'(W + EXTRA - 1);
  localparam logic [6:0] CY_LAST = 7'(H - 1);
  localparam logic [7:0] FG_COLS = 8'(W);
  localparam logic [8:0] CLIP_X  = 9'(SW);
  localparam logic [6:0] Y_BASE  = 7'(Y0);

  sweep_state_t state, state_nxt;
  logic [7:0]   snap_x, snap_nxt;
  logic [7:0]   cx, cx_nxt;
  logic [6:0]   cy, cy_nxt;
  logic         pending, pend_nxt;
  logic         load;
  logic [8:0]   px;

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap_x;
    cx_nxt    = cx;
    cy_nxt    = cy;
    pend_nxt  = pending;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_SWEEP;
          snap_nxt  = x_in;
          cx_nxt    = '0;
          cy_nxt    = '0;
          load      = 1'b1;
        end
      end
      S_SWEEP: begin
        if (req) pend_nxt = 1'b1;
        if (cx == CX_LAST && cy == CY_LAST) begin
          // A request seen on the last pixel still counts as pending.
          if (pending || req) begin
            snap_nxt = x_in;
            cx_nxt   = '0;
            cy_nxt   = '0;
            pend_nxt = 1'b0;
            load     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          load = 1'b1;
          if (cx == CX_LAST) begin
            cx_nxt = '0;
            cy_nxt = cy + 7'd1;
          end else begin
            cx_nxt = cx + 8'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign px = {1'b0, snap_nxt} + {1'b0, cx_nxt};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      snap_x  <= '0;
      cx      <= '0;
      cy      <= '0;
      pending <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
      plot    <= 1'b0;
    end else begin
      state   <= state_nxt;
      snap_x  <= snap_nxt;
      cx      <= cx_nxt;
      cy      <= cy_nxt;
      pending <= pend_nxt;
      plot    <= load && (px < CLIP_X);
      if (load) begin
        x_out  <= px[7:0];
        y_out  <= Y_BASE + cy_nxt;
        colour <= (cx_nxt < FG_COLS) ? FG : BG;
      end
    end
  end

  assign busy = (state == S_SWEEP);

endmodule

// File: rtl/wall_datapath.sv
// rtl/wall_datapath.sv - wall position/touch registers plus redraw sweep for the wall FSM
module wall_datapath
  import wall_pkg::*;
#(
  parameter int X_START = 159,
  parameter int Y_TOP   = 60,
  parameter int WALL_W  = 4,
  parameter int WALL_H  = 20,
  parameter int STEP    = 1,
  parameter int TOUCH_X = 20
) (
  input  logic            clk,
  input  logic            resetn,
  wall_datapath_if.master bus
);

  localparam logic [7:0] X_START_L = 8'(X_START);
  localparam logic [7:0] STEP_L    = 8'(STEP);
  localparam logic [7:0] TOUCH_L   = 8'(TOUCH_X);

  logic [7:0] wall_x, wall_x_nxt;
  logic       touched, touched_nxt;

  always_comb begin
    wall_x_nxt  = wall_x;
    touched_nxt = touched;
    case (bus.current)
      W_READY: begin
        wall_x_nxt  = X_START_L;
        touched_nxt = 1'b0;
      end
      W_MOVE: begin
        if (bus.step_en)
          wall_x_nxt = (wall_x >= STEP_L) ? wall_x - STEP_L : 8'd0;
        touched_nxt = (wall_x_nxt <= TOUCH_L);
      end
      default: touched_nxt = (wall_x_nxt <= TOUCH_L);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wall_x  <= X_START_L;
      touched <= 1'b0;
    end else begin
      wall_x  <= wall_x_nxt;
      touched <= touched_nxt;
    end
  end

  assign bus.wall_x  = wall_x;
  assign bus.touched = touched;

  // Extra STEP columns to the right erase what the last move uncovered.
  pixel_sweep #(
    .W     (WALL_W),
    .H     (WALL_H),
    .EXTRA (STEP),
    .Y0    (Y_TOP),
    .SW    (SCREEN_W),
    .FG    (WALL_COLOUR),
    .BG    (BG_COLOUR)
  ) u_sweep (
    .clk    (clk),
    .resetn (resetn),
    .req    (bus.current == W_DRAW),
    .x_in   (wall_x),
    .x_out  (bus.x_out),
    .y_out  (bus.y_out),
    .colour (bus.colour),
    .plot   (bus.plot),
    .busy   (bus.busy)
  );

endmodule

// File: tb/tb_wall_datapath.sv
// tb/tb_wall_datapath.sv - directed self-checking bench for wall_datapath
module tb_wall_datapath;
  import wall_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  wall_datapath_if bus ();

  wall_datapath dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] cur, input logic se);
    bus.current = cur;
    bus.step_en = se;
  endtask

  initial begin
    int cx, cy, p, s, snap, x, nplot, nact;
    resetn = 1'b0;
    drive(4'b0000, 1'b0);
    tick();
    tick();
    chk("rst_wall_x", 32'(bus.wall_x), 159);
    chk("rst_touched", 32'(bus.touched), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_xyc", {bus.x_out, 1'b0, bus.y_out, bus.colour}, 0);

    resetn = 1'b1;
    drive(W_READY, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ready_wall_x", 32'(bus.wall_x), 159);
      chk("ready_tp", {bus.touched, bus.plot, bus.busy}, 0);
    end

    // single sweep at the right edge: only column 159 is visible
    drive(W_DRAW, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    nplot = 0;
    for (int k = 0; k < 100; k++) begin
      cx = k % 5;
      cy = k / 5;
      chk("sw1_busy", 32'(bus.busy), 1);
      chk("sw1_plot", 32'(bus.plot), (cx == 0) ? 1 : 0);
      if (bus.plot) begin
        nplot++;
        chk("sw1_x", 32'(bus.x_out), 159);
        chk("sw1_y", 32'(bus.y_out), 60 + cy);
        chk("sw1_colour", 32'(bus.colour), 7);
      end
      tick();
    end
    chk("sw1_nplot", nplot, 20);
    chk("sw1_end_busy", 32'(bus.busy), 0);
    chk("sw1_end_plot", 32'(bus.plot), 0);

    drive(W_MOVE, 1'b0);
    tick();
    chk("move_hold", 32'(bus.wall_x), 159);
    drive(W_MOVE, 1'b1);
    tick();
    chk("move_step", 32'(bus.wall_x), 158);
    for (int i = 0; i < 137; i++) tick();
    chk("move_21", 32'(bus.wall_x), 21);
    chk("move_21_t", 32'(bus.touched), 0);
    tick();
    chk("move_20", 32'(bus.wall_x), 20);
    chk("move_20_t", 32'(bus.touched), 1);
    drive(W_STOP, 1'b1);
    tick();
    tick();
    chk("stop_x", 32'(bus.wall_x), 20);
    chk("stop_t", 32'(bus.touched), 1);
    drive(W_MOVE, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("move_0", 32'(bus.wall_x), 0);
    tick();
    chk("move_sat", 32'(bus.wall_x), 0);
    chk("move_sat_t", 32'(bus.touched), 1);
    drive(W_READY, 1'b0);
    tick();
    chk("ready2_x", 32'(bus.wall_x), 159);
    chk("ready2_t", 32'(bus.touched), 0);

    // sweep at 159, move to 150 mid-sweep, three coalesced draw pulses
    drive(W_DRAW, 1'b0);
    tick();
    for (int k = 0; k < 200; k++) begin
      s = k / 100;
      p = k % 100;
      cx = p % 5;
      cy = p / 5;
      snap = (s == 0) ? 159 : 150;
      x = snap + cx;
      chk("co_busy", 32'(bus.busy), 1);
      chk("co_plot", 32'(bus.plot), (x < 160) ? 1 : 0);
      if (x < 160) begin
        chk("co_x", 32'(bus.x_out), x);
        chk("co_y", 32'(bus.y_out), 60 + cy);
        chk("co_colour", 32'(bus.colour), (cx < 4) ? 7 : 0);
      end
      if (k < 9) drive(W_MOVE, 1'b1);
      else if (k == 20 || k == 22 || k == 24) drive(W_DRAW, 1'b0);
      else drive(4'b0000, 1'b0);
      tick();
    end
    chk("co_wall_x", 32'(bus.wall_x), 150);
    chk("co_end_busy", 32'(bus.busy), 0);
    chk("co_end_plot", 32'(bus.plot), 0);

    // reset in the middle of a sweep
    drive(W_DRAW, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    for (int k = 0; k < 50; k++) tick();
    chk("mid_busy", 32'(bus.busy), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("abort_plot", 32'(bus.plot), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_wall_x", 32'(bus.wall_x), 159);
    nact = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus.plot || bus.busy) nact++;
    end
    chk("abort_quiet", nact, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
